// File: rtl/multdiv_sequencer.sv
// Sequences an external 32-bit ALU to perform signed multiply (radix-2 Booth) and signed divide (restoring).
// Defining MULTDIV_REMAINDER_EN adds a data_remainder output and one extra divide cycle.
module multdiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] alu_opA,
    output logic [WIDTH-1:0] alu_opB,
    output logic [4:0]       alu_opcode,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_overflow,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
`ifdef MULTDIV_REMAINDER_EN
    output logic [WIDTH-1:0] data_remainder,
`endif
    output logic             busy
);

    localparam logic [4:0] OP_ADD = 5'b00000;
    localparam logic [4:0] OP_SUB = 5'b00001;

    typedef enum logic [2:0] {
        IDLE, MUL, DIV_ABSA, DIV_ABSB, DIV_ITER, DIV_SIGN, DONE
    } state_t;

    state_t           state, state_n;
    logic [5:0]       cnt, cnt_n;
    logic [WIDTH-1:0] hi, hi_n;     // Booth P_hi / divider partial remainder R
    logic [WIDTH-1:0] lo, lo_n;     // Booth P_lo / dividend then quotient Q
    logic [WIDTH-1:0] m, m_n;       // multiplicand / divisor magnitude
    logic             q_1, q1_n;
    logic             s_a, sa_n, s_b, sb_n;
    logic [WIDTH-1:0] result_n;
    logic             exc_n, rdy_n, busy_n;
`ifdef MULTDIV_REMAINDER_EN
    logic [WIDTH-1:0] rem_n;
`endif

    logic             booth_use, booth_msb, borrow, div_ovf;
    logic [WIDTH-1:0] booth_s;
    logic [WIDTH:0]   r_sh;

    always_comb begin
        // NOTE: every next value defaults to its current value first, so no branch can infer a latch.
        state_n    = state;
        cnt_n      = cnt;
        hi_n       = hi;
        lo_n       = lo;
        m_n        = m;
        q1_n       = q_1;
        sa_n       = s_a;
        sb_n       = s_b;
        result_n   = data_result;
        exc_n      = data_exception;
        rdy_n      = 1'b0;
        busy_n     = busy;
`ifdef MULTDIV_REMAINDER_EN
        rem_n      = data_remainder;
`endif
        alu_opA    = '0;
        alu_opB    = '0;
        alu_opcode = OP_ADD;
        booth_use  = lo[0] ^ q_1;
        booth_s    = hi;
        booth_msb  = hi[WIDTH-1];
        r_sh       = {hi, lo[WIDTH-1]};
        borrow     = 1'b0;
        // Only a positive quotient of 2^31 (i.e. 0x80000000 / -1) is unrepresentable.
        div_ovf    = ~(s_a ^ s_b) & lo[WIDTH-1];

        case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (ctrl_MULT || ctrl_DIV) begin
                    state_n = ctrl_MULT ? MUL : DIV_ABSA;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    hi_n    = '0;
                    lo_n    = data_operandA;
                    m_n     = data_operandB;
                    q1_n    = 1'b0;
                    sa_n    = data_operandA[WIDTH-1];
                    sb_n    = data_operandB[WIDTH-1];
                end
            end

            MUL: begin
                alu_opA    = hi;
                alu_opB    = m;
                alu_opcode = (lo[0] & ~q_1) ? OP_SUB : OP_ADD;
                if (booth_use) begin
                    booth_s   = alu_result;
                    booth_msb = alu_result[WIDTH-1] ^ alu_overflow;
                end
                hi_n  = {booth_msb, booth_s[WIDTH-1:1]};
                lo_n  = {booth_s[0], lo[WIDTH-1:1]};
                q1_n  = lo[0];
                cnt_n = cnt + 6'd1;
                if (cnt == 6'(WIDTH - 1)) begin
                    result_n = lo_n;
                    exc_n    = (hi_n != {WIDTH{lo_n[WIDTH-1]}});
                    rdy_n    = 1'b1;
                    busy_n   = 1'b0;
`ifdef MULTDIV_REMAINDER_EN
                    rem_n    = '0;
`endif
                    state_n  = DONE;
                end
            end

            DIV_ABSA: begin
                if (m == '0) begin
                    result_n = '0;
                    exc_n    = 1'b1;
                    rdy_n    = 1'b1;
                    busy_n   = 1'b0;
`ifdef MULTDIV_REMAINDER_EN
                    rem_n    = '0;
`endif
                    state_n  = DONE;
                end else begin
                    if (s_a) begin
                        alu_opB    = lo;
                        alu_opcode = OP_SUB;
                        lo_n       = alu_result;
                    end
                    state_n = DIV_ABSB;
                end
            end

            DIV_ABSB: begin
                if (s_b) begin
                    alu_opB    = m;
                    alu_opcode = OP_SUB;
                    m_n        = alu_result;
                end
                state_n = DIV_ITER;
            end

            DIV_ITER: begin
                alu_opA    = r_sh[WIDTH-1:0];
                alu_opB    = m;
                alu_opcode = OP_SUB;
                borrow     = (~r_sh[WIDTH-1] & m[WIDTH-1]) |
                             (~(r_sh[WIDTH-1] ^ m[WIDTH-1]) & alu_result[WIDTH-1]);
                if (r_sh[WIDTH] || !borrow) begin
                    hi_n = alu_result;
                    lo_n = {lo[WIDTH-2:0], 1'b1};
                end else begin
                    hi_n = r_sh[WIDTH-1:0];
                    lo_n = {lo[WIDTH-2:0], 1'b0};
                end
                cnt_n = cnt + 6'd1;
                if (cnt == 6'(WIDTH - 1)) state_n = DIV_SIGN;
            end

            DIV_SIGN: begin
`ifdef MULTDIV_REMAINDER_EN
                // First cycle fixes the quotient sign in place, second negates the remainder.
                if (cnt == 6'(WIDTH)) begin
                    if (s_a ^ s_b) begin
                        alu_opB    = lo;
                        alu_opcode = OP_SUB;
                        lo_n       = alu_result;
                    end
                    cnt_n = cnt + 6'd1;
                end else begin
                    if (s_a) begin
                        alu_opB    = hi;
                        alu_opcode = OP_SUB;
                    end
                    result_n = div_ovf ? '0 : lo;
                    rem_n    = div_ovf ? '0 : (s_a ? alu_result : hi);
                    exc_n    = div_ovf;
                    rdy_n    = 1'b1;
                    busy_n   = 1'b0;
                    state_n  = DONE;
                end
`else
                if (s_a ^ s_b) begin
                    alu_opB    = lo;
                    alu_opcode = OP_SUB;
                end
                result_n = div_ovf ? '0 : ((s_a ^ s_b) ? alu_result : lo);
                exc_n    = div_ovf;
                rdy_n    = 1'b1;
                busy_n   = 1'b0;
                state_n  = DONE;
`endif
            end

            default: state_n = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state          <= IDLE;
            cnt            <= '0;
            hi             <= '0;
            lo             <= '0;
            m              <= '0;
            q_1            <= 1'b0;
            s_a            <= 1'b0;
            s_b            <= 1'b0;
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            busy           <= 1'b0;
`ifdef MULTDIV_REMAINDER_EN
            data_remainder <= '0;
`endif
        end else begin
            state          <= state_n;
            cnt            <= cnt_n;
            hi             <= hi_n;
            lo             <= lo_n;
            m              <= m_n;
            q_1            <= q1_n;
            s_a            <= sa_n;
            s_b            <= sb_n;
            data_result    <= result_n;
            data_exception <= exc_n;
            data_resultRDY <= rdy_n;
            busy           <= busy_n;
`ifdef MULTDIV_REMAINDER_EN
            data_remainder <= rem_n;
`endif
        end
    end

endmodule

// File: tb/tb_multdiv_sequencer.sv
// Directed self-checking bench for multdiv_sequencer with a behavioural 32-bit add/subtract ALU.
// Honours MULTDIV_REMAINDER_EN for divide latency and remainder checks.
module tb_multdiv_sequencer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        ctrl_MULT = 1'b0;
    logic        ctrl_DIV = 1'b0;
    logic [31:0] data_operandA = '0;
    logic [31:0] data_operandB = '0;
    logic [31:0] alu_opA, alu_opB, alu_result, data_result;
    logic [4:0]  alu_opcode;
    logic        alu_overflow, data_exception, data_resultRDY, busy;
`ifdef MULTDIV_REMAINDER_EN
    logic [31:0] data_remainder;
    localparam int DIV_LAT = 36;
`else
    localparam int DIV_LAT = 35;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int edge_cnt = 0;
    int e0 = 0;
    int pulses;

    always #5 clock = ~clock;
    always @(posedge clock) edge_cnt <= edge_cnt + 1;

    // Reference ALU: 00001 subtracts, anything else adds; overflow is signed.
    logic alu_sub;
    assign alu_sub      = (alu_opcode == 5'b00001);
    assign alu_result   = alu_sub ? (alu_opA - alu_opB) : (alu_opA + alu_opB);
    assign alu_overflow = alu_sub
        ? ((alu_opA[31] != alu_opB[31]) && (alu_result[31] != alu_opA[31]))
        : ((alu_opA[31] == alu_opB[31]) && (alu_result[31] != alu_opA[31]));

    multdiv_sequencer dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .alu_opA        (alu_opA),
        .alu_opB        (alu_opB),
        .alu_opcode     (alu_opcode),
        .alu_result     (alu_result),
        .alu_overflow   (alu_overflow),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
`ifdef MULTDIV_REMAINDER_EN
        .data_remainder (data_remainder),
`endif
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives a start for the E0 edge, then scrambles operands to prove they were captured.
    task automatic start_op(input logic mult, input logic div, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = mult;
        ctrl_DIV      = div;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        e0            = edge_cnt;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h1234_5678;
        check("busy_after_start", {31'b0, busy}, 32'd1);
    endtask

    task automatic wait_done(input string tag, input int exp_lat, input logic [31:0] exp_res,
                             input logic exp_exc);
        int lat;
        lat = -1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                lat = edge_cnt - e0;
                break;
            end
        end
        check({tag, "_latency"}, lat, exp_lat);
        check({tag, "_result"}, data_result, exp_res);
        check({tag, "_exception"}, {31'b0, data_exception}, {31'b0, exp_exc});
        check({tag, "_busy_at_rdy"}, {31'b0, busy}, 32'd0);
        @(posedge clock);
        #1;
        check({tag, "_rdy_one_cycle"}, {31'b0, data_resultRDY}, 32'd0);
    endtask

    task automatic count_rdy(input int cycles, output int n);
        n = 0;
        repeat (cycles) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) n++;
        end
    endtask

    initial begin
        #12;
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_rdy", {31'b0, data_resultRDY}, 32'd0);
        check("reset_result", data_result, 32'd0);
        check("reset_exception", {31'b0, data_exception}, 32'd0);
        check("reset_alu_opA", alu_opA, 32'd0);
        check("reset_alu_opcode", {27'b0, alu_opcode}, 32'd0);
        @(negedge clock);
        reset = 1'b1;

        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        wait_done("mul_7_m3", 32, 32'hFFFF_FFEB, 1'b0);
        check("idle_alu_opcode", {27'b0, alu_opcode}, 32'd0);
`ifdef MULTDIV_REMAINDER_EN
        check("mul_7_m3_rem", data_remainder, 32'd0);
`endif

        start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        wait_done("mul_ovf", 32, 32'h0000_0000, 1'b1);

        start_op(1'b1, 1'b0, 32'h8000_0000, 32'd1);
        wait_done("mul_min_x1", 32, 32'h8000_0000, 1'b0);

        start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        wait_done("div_m7_2", DIV_LAT, 32'hFFFF_FFFD, 1'b0);
`ifdef MULTDIV_REMAINDER_EN
        check("div_m7_2_rem", data_remainder, 32'hFFFF_FFFF);
`endif

        start_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
        wait_done("div_100_m7", DIV_LAT, 32'hFFFF_FFF2, 1'b0);
`ifdef MULTDIV_REMAINDER_EN
        check("div_100_m7_rem", data_remainder, 32'd2);
`endif

        start_op(1'b0, 1'b1, 32'd5, 32'd0);
        wait_done("div_by_zero", 1, 32'd0, 1'b1);

        start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done("div_ovf", DIV_LAT, 32'd0, 1'b1);
`ifdef MULTDIV_REMAINDER_EN
        check("div_ovf_rem", data_remainder, 32'd0);
`endif

        start_op(1'b1, 1'b1, 32'd6, 32'd4);
        wait_done("both_start", 32, 32'd24, 1'b0);

        start_op(1'b1, 1'b0, 32'd5, 32'd5);
        repeat (5) @(negedge clock);
        ctrl_DIV      = 1'b1;
        data_operandB = 32'd0;
        @(negedge clock);
        ctrl_DIV      = 1'b0;
        wait_done("div_pulse_ignored", 32, 32'd25, 1'b0);
        count_rdy(45, pulses);
        check("single_rdy_after_pulse", pulses, 32'd0);

        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_rdy", {31'b0, data_resultRDY}, 32'd0);
        check("abort_result", data_result, 32'd0);
        repeat (2) @(negedge clock);
        reset = 1'b1;
        count_rdy(40, pulses);
        check("abort_no_rdy", pulses, 32'd0);
        check("abort_idle_busy", {31'b0, busy}, 32'd0);

        start_op(1'b1, 1'b0, 32'd3, 32'd3);
        wait_done("mul_3_3", 32, 32'd9, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multdiv_sequencer.md
Name: multdiv_sequencer

Overview:
Multicycle controller that sequences the shared 32-bit ALU adder/subtractor to do signed multiply and signed divide. Multiply uses radix-2 Booth in 32 steps; divide uses restoring division on magnitudes with sign correction. The block owns no adder. Every add and subtract goes out on alu_* ports to the ALU, opcode 00000 = add, 00001 = subtract. It sits beside the ALU in the execute stage and stalls the pipeline through busy.

Parameters:
WIDTH, 32, operand/result width; the ALU interface is fixed at 32, so only 32 is supported.

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous reset, active-low (asserted when 0)
ctrl_MULT  in  1  start multiply; sampled only in IDLE
ctrl_DIV  in  1  start divide; sampled only in IDLE
data_operandA  in  32  multiplicand / dividend, captured at start edge
data_operandB  in  32  multiplier / divisor, captured at start edge
alu_opA  out  32  ALU operand A
alu_opB  out  32  ALU operand B
alu_opcode  out  5  00000 add, 00001 subtract
alu_result  in  32  ALU sum/difference, combinational from alu_*
alu_overflow  in  1  ALU signed overflow
data_result  out  32  product low word / quotient
data_exception  out  1  overflow or divide-by-zero, valid with data_resultRDY
data_resultRDY  out  1  one-cycle completion pulse
busy  out  1  operation in flight

Behaviour:
- Reset (reset=0, async) → state IDLE; data_result=0, data_exception=0, data_resultRDY=0, busy=0, all internal registers 0. Reset mid-operation aborts it; no RDY pulse follows.
- Idle outputs: alu_opA=0, alu_opB=0, alu_opcode=00000 in IDLE and DONE.
- Start edge E0 (in IDLE):
  - ctrl_MULT=1 → MUL.
  - else ctrl_DIV=1 → DIV.
  - Both high → multiply wins.
  - Starts while busy=1 are ignored.
  - busy=1 from E0 until the RDY edge.
- States: IDLE, MUL, DIV_ABSA, DIV_ABSB, DIV_ITER, DIV_SIGN, DONE. A 6-bit step counter is cleared at E0.
- MUL, edges E1..E32, one Booth step each:
  - Registers: P_hi, P_lo (init A), q_1 (init 0), M (init B).
  - Per step: alu_opA=P_hi, alu_opB=M.
  - {P_lo[0],q_1}=01 → opcode add; =10 → subtract; 00/11 → add with alu_result discarded.
  - Selected sum S = alu_result, or P_hi if discarded.
  - New MSB = S[31]^alu_overflow when ALU used, else P_hi[31].
  - Arithmetic right shift of {MSB,S,P_lo,q_1} by 1.
  - At E32: data_result=P_lo (post-shift), data_exception = (P_hi != {32{P_lo[31]}}), data_resultRDY=1, busy=0, → DONE.
- DIV:
  - At E0: record sA=A[31], sB=B[31].
  - If B==0: at E1 data_result=0, data_exception=1, RDY=1, busy=0; skip all other states.
  - DIV_ABSA (E1): if sA, alu_opA=0, alu_opB=A, subtract, load result as |A|.
  - DIV_ABSB (E2): same for |B|.
  - DIV_ITER, edges E3..E34:
    - Shift {R33,Q} left by 1, Q bit 0 = 0.
    - alu_opA=R[31:0], alu_opB=|B|, subtract.
    - borrow = (~a31&b31) | (~(a31^b31)&res31).
    - If R[32] | ~borrow: R=alu_result, Q[0]=1; else R unchanged.
  - DIV_SIGN (E35): if sA^sB, ALU computes 0−Q.
    - data_result = that value, else Q.
    - data_exception=1 and data_result=0 iff A=0x80000000 and B=0xFFFFFFFF.
    - RDY=1, busy=0.
- Quotient truncates toward zero.
- Latency: multiply RDY high E32–E33; divide E35–E36; divide-by-zero E1–E2.
- DONE lasts one cycle; RDY clears; → IDLE. A new start is accepted at the edge leaving DONE.
- data_result/data_exception hold until the next RDY.

Optional Feature:
MULTDIV_REMAINDER_EN.
- Defined: adds output data_remainder (32), updated with RDY.
  - Divide: remainder carries the dividend's sign. DIV_SIGN uses one extra cycle (E36) to negate it when sA=1, so divide latency becomes 36.
  - Multiply, divide-by-zero and overflow: remainder=0.
- Undefined: no port, no extra cycle.

Test Plan:
- MULT A=7, B=−3 → RDY pulse at E32 only, data_result=0xFFFFFFEB, exception=0, busy low same edge.
- MULT A=0x00010000, B=0x00010000 → data_result=0x00000000, exception=1; MULT 0x80000000×1 → 0x80000000, exception=0.
- DIV A=−7, B=2 → RDY at E35, data_result=0xFFFFFFFD; with MULTDIV_REMAINDER_EN RDY at E36, remainder=0xFFFFFFFF.
- DIV A=5, B=0 → RDY at E1, exception=1, result 0; DIV 0x80000000/0xFFFFFFFF → exception=1, result 0.
- ctrl_MULT and ctrl_DIV both high (A=6, B=4) → product 24; ctrl_DIV pulsed mid-operation → ignored, single RDY.
- reset=0 at E10 of a multiply → busy, RDY and result 0 immediately; no RDY afterward; next MULT 3×3 → 9.
